// File: rtl/spi_slv_buf.sv
// rtl/spi_slv_buf.sv - buffered SPI slave with 128-bit transmit and receive buffers
module spi_slv_buf #(
    parameter bit MODE_16B = 1'b0,
    parameter bit CPOL     = 1'b0,
    parameter bit CPHA     = 1'b0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [127:0] slv_wfifo,
    input  logic [7:0]   slv_ctrl,
    output logic [127:0] slv_rfifo,
    output logic [7:0]   slv_status,
    input  logic         scl,
    input  logic         ss,
    input  logic         mosi,
    output logic         miso
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Synchronizer chains: [0] first flop, [1] synced value, [2] previous synced value
    logic [2:0]   scl_sync_q;
    logic [2:0]   ss_sync_q;
    logic [1:0]   mosi_sync_q;

    state_t       state_q;
    logic [127:0] tx_q;
    logic [127:0] rx_q;
    logic [127:0] rfifo_q;
    logic [7:0]   status_q;
    logic [7:0]   cnt_q;
    logic [3:0]   len_q;
    logic         miso_q;
    logic         ctrl7_q;
    // Arm and ss fall seen in the same cycle: enter SHIFT next cycle if ss is still low
    logic         pend_q;
    // With CPHA=0 the shift edge right after the final sample is part of the frame, not overrun
    logic         skip_q;

    logic         scl_rise;
    logic         scl_fall;
    logic         scl_edge;
    logic         sample_edge;
    logic         shift_edge;
    logic         ss_fall;
    logic         ss_rise;
    logic         ss_low;
    logic         mosi_s;
    logic         arm;
    logic [3:0]   len_d;
    logic [4:0]   len_p1;
    logic [7:0]   nbits;
    logic [7:0]   cnt_d;
    logic [7:0]   full_shamt;
    logic [7:0]   part_shamt;
    logic [127:0] rx_d;
    logic [3:0]   units;
    logic [3:0]   short_idx_d;
    logic         unused_ctrl;

    assign unused_ctrl = ^slv_ctrl[6:4];

    // Two-flop synchronizers plus one history flop for edge detection
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            scl_sync_q  <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
        end else begin
            scl_sync_q  <= {scl_sync_q[1:0], scl};
            ss_sync_q   <= {ss_sync_q[1:0], ss};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
        end
    end

    // Edge events, frame length and shift results for the FSM
    always_comb begin
        scl_rise    = scl_sync_q[1] & ~scl_sync_q[2];
        scl_fall    = ~scl_sync_q[1] & scl_sync_q[2];
        scl_edge    = scl_rise | scl_fall;
        sample_edge = (CPOL == CPHA) ? scl_rise : scl_fall;
        shift_edge  = (CPOL == CPHA) ? scl_fall : scl_rise;
        ss_fall     = ~ss_sync_q[1] & ss_sync_q[2];
        ss_rise     = ss_sync_q[1] & ~ss_sync_q[2];
        ss_low      = ~ss_sync_q[1];
        mosi_s      = mosi_sync_q[1];
        arm         = slv_ctrl[7] & ~ctrl7_q;

        // 16-bit units cap the frame at 8 units (128 bits)
        if (MODE_16B) begin
            len_d = slv_ctrl[3] ? 4'd7 : {1'b0, slv_ctrl[2:0]};
        end else begin
            len_d = slv_ctrl[3:0];
        end

        len_p1 = {1'b0, len_q} + 5'd1;
        if (MODE_16B) begin
            nbits = {len_p1[3:0], 4'd0};
        end else begin
            nbits = {len_p1, 3'd0};
        end

        cnt_d      = cnt_q + 8'd1;
        rx_d       = {rx_q[126:0], mosi_s};
        full_shamt = 8'd128 - nbits;
        part_shamt = 8'd128 - cnt_q;

        if (MODE_16B) begin
            units = cnt_q[7:4];
        end else begin
            units = cnt_q[6:3];
        end
        short_idx_d = (units == 4'd0) ? 4'd0 : units - 4'd1;
    end

    // Frame control FSM; all outputs are registered here
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q  <= ST_IDLE;
            tx_q     <= '0;
            rx_q     <= '0;
            rfifo_q  <= '0;
            status_q <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            miso_q   <= 1'b0;
            ctrl7_q  <= 1'b0;
            pend_q   <= 1'b0;
            skip_q   <= 1'b0;
        end else begin
            ctrl7_q <= slv_ctrl[7];
            case (state_q)
                ST_IDLE: begin
                    miso_q <= 1'b0;
                    if (arm) begin
                        tx_q     <= slv_wfifo;
                        len_q    <= len_d;
                        rx_q     <= '0;
                        cnt_q    <= '0;
                        status_q <= 8'h80;
                        pend_q   <= ss_fall;
                        state_q  <= ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    pend_q <= 1'b0;
                    if (ss_fall || (pend_q && ss_low)) begin
                        cnt_q   <= '0;
                        rx_q    <= '0;
                        state_q <= ST_SHIFT;
                        // CPHA=0 presents the first bit before the first clock edge
                        if (!CPHA) begin
                            miso_q <= tx_q[127];
                            tx_q   <= {tx_q[126:0], 1'b0};
                        end
                    end
                end

                ST_SHIFT: begin
                    if (ss_rise) begin
                        // Master ended the frame early: keep what arrived, left-aligned
                        rfifo_q  <= rx_q << part_shamt;
                        status_q <= {4'b0001, short_idx_d};
                        miso_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else if (sample_edge) begin
                        rx_q  <= rx_d;
                        cnt_q <= cnt_d;
                        if (cnt_d == nbits) begin
                            rfifo_q       <= rx_d << full_shamt;
                            status_q[6]   <= 1'b1;
                            status_q[3:0] <= len_q;
                            miso_q        <= 1'b0;
                            skip_q        <= ~CPHA;
                            state_q       <= ST_DONE;
                        end
                    end else if (shift_edge) begin
                        miso_q <= tx_q[127];
                        tx_q   <= {tx_q[126:0], 1'b0};
                    end
                end

                ST_DONE: begin
                    miso_q <= 1'b0;
                    if (ss_rise) begin
                        status_q[7] <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else if (scl_edge && ss_low) begin
                        if (skip_q) begin
                            skip_q <= 1'b0;
                        end else begin
                            status_q[5] <= 1'b1;
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign slv_rfifo  = rfifo_q;
    assign slv_status = status_q;
    assign miso       = miso_q;

endmodule

// File: tb/tb_spi_slv_buf.sv
// tb/tb_spi_slv_buf.sv - self-checking bench for spi_slv_buf across four mode configurations
module tb_spi_slv_buf;

    // Per-instance configuration: u0 mode0 8b, u1 CPOL1/CPHA1 8b, u2 16b mode0, u3 CPOL0/CPHA1 8b
    localparam bit [3:0] P_M16  = 4'b0100;
    localparam bit [3:0] P_CPOL = 4'b0010;
    localparam bit [3:0] P_CPHA = 4'b1010;

    typedef struct {
        int           inst;
        logic [3:0]   len;
        logic [127:0] tx;
        logic [127:0] m;
        int           nsent;
        logic [127:0] e_rf;
        logic [7:0]   e_st;
        logic [127:0] e_mrx;
    } vec_t;

    logic         clk = 1'b0;
    logic         rstn;
    logic [127:0] wfifo;
    logic [7:0]   ctrl;
    logic         ss;
    logic         mosi;
    logic         scl_base;
    logic [3:0]   scl_w;
    logic [3:0]   miso_w;
    logic [127:0] rf_w [4];
    logic [7:0]   st_w [4];

    int nvec = 0;
    int nerr = 0;

    logic [127:0] tx_m;
    logic [3:0]   len_m;
    bit           armed_m;
    logic [127:0] prev_rf [4];
    logic [7:0]   prev_st [4];
    logic [127:0] mrx [4];
    vec_t         tbl [5];

    always #5 clk = ~clk;

    assign scl_w = {4{scl_base}} ^ P_CPOL;

    spi_slv_buf #(.MODE_16B(1'b0), .CPOL(1'b0), .CPHA(1'b0)) u0 (
        .clk(clk), .rstn(rstn), .slv_wfifo(wfifo), .slv_ctrl(ctrl),
        .slv_rfifo(rf_w[0]), .slv_status(st_w[0]),
        .scl(scl_w[0]), .ss(ss), .mosi(mosi), .miso(miso_w[0]));

    spi_slv_buf #(.MODE_16B(1'b0), .CPOL(1'b1), .CPHA(1'b1)) u1 (
        .clk(clk), .rstn(rstn), .slv_wfifo(wfifo), .slv_ctrl(ctrl),
        .slv_rfifo(rf_w[1]), .slv_status(st_w[1]),
        .scl(scl_w[1]), .ss(ss), .mosi(mosi), .miso(miso_w[1]));

    spi_slv_buf #(.MODE_16B(1'b1), .CPOL(1'b0), .CPHA(1'b0)) u2 (
        .clk(clk), .rstn(rstn), .slv_wfifo(wfifo), .slv_ctrl(ctrl),
        .slv_rfifo(rf_w[2]), .slv_status(st_w[2]),
        .scl(scl_w[2]), .ss(ss), .mosi(mosi), .miso(miso_w[2]));

    spi_slv_buf #(.MODE_16B(1'b0), .CPOL(1'b0), .CPHA(1'b1)) u3 (
        .clk(clk), .rstn(rstn), .slv_wfifo(wfifo), .slv_ctrl(ctrl),
        .slv_rfifo(rf_w[3]), .slv_status(st_w[3]),
        .scl(scl_w[3]), .ss(ss), .mosi(mosi), .miso(miso_w[3]));

    task automatic check(input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[u%0d]: got %h, expected %h", name, k, act, exp);
        end
    endtask

    // Reference: what a slave obeying the frame rules must end up with after ss has risen
    task automatic model(input int k, input int nsent, input logic [127:0] m,
                         output logic [127:0] e_rf, output logic [7:0] e_st, output logic [127:0] e_mrx);
        int unit;
        int lenc;
        int n;
        int units;
        e_mrx = '0;
        if (!armed_m) begin
            e_rf = prev_rf[k];
            e_st = prev_st[k];
        end else begin
            unit = P_M16[k] ? 16 : 8;
            lenc = int'(len_m);
            if (P_M16[k] && lenc > 7) lenc = 7;
            n = (lenc + 1) * unit;
            e_rf = '0;
            for (int i = 0; i < nsent && i < n; i++) begin
                e_mrx[127-i] = tx_m[127-i];
                e_rf[127-i]  = m[127-i];
            end
            if (nsent >= n) begin
                e_st = 8'h40 | ((nsent > n) ? 8'h20 : 8'h00) | 8'(lenc);
            end else begin
                units = nsent / unit;
                e_st  = 8'h10 | 8'((units > 0) ? units - 1 : 0);
            end
        end
    endtask

    task automatic do_arm(input logic [127:0] tx, input logic [3:0] len);
        @(negedge clk);
        wfifo = tx;
        ctrl  = {4'b0000, len};
        @(negedge clk);
        ctrl[7] = 1'b1;
        @(negedge clk);
        ctrl[7] = 1'b0;
        wfifo   = ~tx;
        ctrl[3:0] = ~len;
        repeat (2) @(negedge clk);
        tx_m    = tx;
        len_m   = len;
        armed_m = 1'b1;
        for (int k = 0; k < 4; k++) check("busy_after_arm", k, {120'd0, st_w[k]}, 128'h80);
    endtask

    // One master frame of nsent bits; mosi changes mid idle phase so both CPHA settings see stable data
    task automatic frame(input int nsent, input logic [127:0] m, input bit poke, input int rst_bit,
                         input bit arm_on_fall, input logic [127:0] atx, input logic [3:0] alen);
        logic [127:0] e_rf;
        logic [7:0]   e_st;
        logic [127:0] e_mrx;
        for (int k = 0; k < 4; k++) mrx[k] = '0;
        @(negedge clk);
        if (arm_on_fall) begin
            wfifo = atx;
            ctrl  = {4'b0000, alen};
            @(negedge clk);
        end
        ss = 1'b0;
        if (arm_on_fall) begin
            repeat (2) @(negedge clk);
            ctrl[7] = 1'b1;
            @(negedge clk);
            ctrl[7] = 1'b0;
            tx_m    = atx;
            len_m   = alen;
            armed_m = 1'b1;
            repeat (5) @(negedge clk);
        end else begin
            repeat (8) @(negedge clk);
        end
        for (int i = 0; i < nsent; i++) begin
            if (i == rst_bit) begin
                rstn = 1'b1;
                #1;
                for (int k = 0; k < 4; k++) begin
                    check("rst_rfifo", k, rf_w[k], 128'h0);
                    check("rst_status", k, {120'd0, st_w[k]}, 128'h0);
                    check("rst_miso", k, {127'd0, miso_w[k]}, 128'h0);
                    prev_rf[k] = '0;
                    prev_st[k] = '0;
                end
                armed_m = 1'b0;
                @(negedge clk);
                rstn = 1'b0;
            end
            mosi = m[127-i];
            if (poke && i == 3) begin
                wfifo     = {$urandom, $urandom, $urandom, $urandom};
                ctrl[3:0] = 4'($urandom_range(0, 15));
                ctrl[7]   = 1'b1;
            end
            if (poke && i == 6) ctrl[7] = 1'b0;
            repeat (3) @(negedge clk);
            for (int k = 0; k < 4; k++) if (!P_CPHA[k]) mrx[k][127-i] = miso_w[k];
            scl_base = 1'b1;
            repeat (6) @(negedge clk);
            for (int k = 0; k < 4; k++) if (P_CPHA[k]) mrx[k][127-i] = miso_w[k];
            scl_base = 1'b0;
            repeat (3) @(negedge clk);
        end
        ctrl[7] = 1'b0;
        repeat (3) @(negedge clk);
        ss = 1'b1;
        repeat (8) @(negedge clk);
        mosi = 1'b0;
        for (int k = 0; k < 4; k++) begin
            model(k, nsent, m, e_rf, e_st, e_mrx);
            check("rfifo", k, rf_w[k], e_rf);
            check("status", k, {120'd0, st_w[k]}, {120'd0, e_st});
            if (rst_bit < 0) check("master_rx", k, mrx[k], e_mrx);
            prev_rf[k] = e_rf;
            prev_st[k] = e_st;
        end
        armed_m = 1'b0;
    endtask

    initial begin
        logic [127:0] rtx;
        logic [127:0] rm;
        int           rn;

        tbl[0] = '{inst: 0, len: 4'd7, tx: {4{32'hCAFE_EFAB}}, m: {16{8'h5a}}, nsent: 64,
                   e_rf: {{8{8'h5a}}, 64'h0}, e_st: 8'h47, e_mrx: {64'hCAFEEFABCAFEEFAB, 64'h0}};
        tbl[1] = '{inst: 1, len: 4'd5, tx: {4{32'hBABE_FACE}}, m: {16{8'h5a}}, nsent: 48,
                   e_rf: {{6{8'h5a}}, 80'h0}, e_st: 8'h45, e_mrx: {48'hBABEFACEBABE, 80'h0}};
        tbl[2] = '{inst: 2, len: 4'd9, tx: 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, m: {128{1'b1}}, nsent: 128,
                   e_rf: {128{1'b1}}, e_st: 8'h47, e_mrx: 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0};
        tbl[3] = '{inst: 0, len: 4'd3, tx: 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978,
                   m: 128'hABCDEF01_23456789_00000000_00000000, nsent: 12,
                   e_rf: 128'hABC00000_00000000_00000000_00000000, e_st: 8'h10,
                   e_mrx: 128'h12300000_00000000_00000000_00000000};
        tbl[4] = '{inst: 0, len: 4'd0, tx: 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978,
                   m: 128'hA53C0000_FFFF0000_11112222_33334444, nsent: 16,
                   e_rf: {8'hA5, 120'h0}, e_st: 8'h60, e_mrx: {8'h12, 120'h0}};

        rstn = 1'b1;
        ss = 1'b1;
        mosi = 1'b0;
        scl_base = 1'b0;
        wfifo = '0;
        ctrl = '0;
        armed_m = 1'b0;
        tx_m = '0;
        len_m = '0;
        for (int k = 0; k < 4; k++) begin
            prev_rf[k] = '0;
            prev_st[k] = '0;
        end

        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("reset_rfifo", k, rf_w[k], 128'h0);
            check("reset_status", k, {120'd0, st_w[k]}, 128'h0);
            check("reset_miso", k, {127'd0, miso_w[k]}, 128'h0);
        end
        rstn = 1'b0;
        repeat (5) @(negedge clk);

        for (int t = 0; t < 5; t++) begin
            do_arm(tbl[t].tx, tbl[t].len);
            frame(tbl[t].nsent, tbl[t].m, 1'b0, -1, 1'b0, '0, 4'd0);
            check("tbl_rfifo", tbl[t].inst, rf_w[tbl[t].inst], tbl[t].e_rf);
            check("tbl_status", tbl[t].inst, {120'd0, st_w[tbl[t].inst]}, {120'd0, tbl[t].e_st});
            check("tbl_master_rx", tbl[t].inst, mrx[tbl[t].inst], tbl[t].e_mrx);
        end

        // Arm edge lands on the same cycle the synced ss fall is seen
        rtx = {$urandom, $urandom, $urandom, $urandom};
        rm  = {$urandom, $urandom, $urandom, $urandom};
        frame(64, rm, 1'b0, -1, 1'b1, rtx, 4'd7);

        // Armed while ss already low, then ss rises in ARMED: frame still starts on the next fall
        ss = 1'b0;
        repeat (10) @(negedge clk);
        do_arm({$urandom, $urandom, $urandom, $urandom}, 4'd3);
        ss = 1'b1;
        repeat (10) @(negedge clk);
        frame(32, {$urandom, $urandom, $urandom, $urandom}, 1'b0, -1, 1'b0, '0, 4'd0);

        // Frame with no arm: nothing may change and miso stays low
        frame(24, {$urandom, $urandom, $urandom, $urandom}, 1'b0, -1, 1'b0, '0, 4'd0);

        // Reset during bit 20 of a 64-bit frame, then a clean frame
        do_arm({$urandom, $urandom, $urandom, $urandom}, 4'd7);
        frame(64, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 20, 1'b0, '0, 4'd0);
        do_arm({$urandom, $urandom, $urandom, $urandom}, 4'd7);
        frame(64, {$urandom, $urandom, $urandom, $urandom}, 1'b0, -1, 1'b0, '0, 4'd0);

        // Randomized frames, with mid-frame changes to the host side that must be ignored
        for (int r = 0; r < 8; r++) begin
            rtx = {$urandom, $urandom, $urandom, $urandom};
            rm  = {$urandom, $urandom, $urandom, $urandom};
            rn  = int'($urandom_range(1, 128));
            do_arm(rtx, 4'($urandom_range(0, 15)));
            frame(rn, rm, 1'($urandom_range(0, 1)), -1, 1'b0, '0, 4'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/spi_slv_buf.md
Name: spi_slv_buf

Overview:
- Buffered SPI slave: the responder end for `spi_master`, with a register-style parallel side that mirrors the master's `wfifo`/`ctrl`/`rfifo`/`status` interface.
- The local host loads a 128-bit transmit buffer and arms the block; the external master then clocks the frame.
- Received bits land left-aligned in a 128-bit receive buffer, and status reports completion.
- Sits in the system clock domain (100 MHz) and oversamples `scl`/`ss`/`mosi`.

Parameters:
- MODE_16B, 0, unit size: 0 = 8-bit units, 1 = 16-bit units.
- CPOL, 0, idle level of `scl`.
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.

Ports:
- clk  input  1  system clock, ≥8× `scl` frequency.
- rstn  input  1  reset rstn, asynchronous, active-high.
- slv_wfifo  input  128  transmit data, MSB (bit 127) sent first.
- slv_ctrl  input  8  [7] arm request (rising edge), [3:0] len; frame = (len+1) units; [6:4] reserved.
- slv_rfifo  output  128  received data, left-aligned.
- slv_status  output  8  [7] busy, [6] done (sticky), [5] overrun, [4] short frame, [3:0] index of last complete unit.
- scl  input  1  SPI clock from master.
- ss  input  1  slave select, active-low.
- mosi  input  1  master-out data.
- miso  output  1  slave-out data; 0 whenever not driving frame data.

Behaviour:
- Reset values: `slv_rfifo`=0, `slv_status`=0, `miso`=0, FSM=IDLE, all shift registers and counters 0.
- Input sync and edge detection:
  - `scl`, `ss` and `mosi` each pass through a 2-flop synchronizer; edges are detected one cycle later.
  - Pin-to-internal-event latency is 3 clk.
  - `miso` updates 1 clk after the detected shift edge.
- Edge roles:
  - Sample edge = rising `scl` when CPOL==CPHA, else falling; shift edge is the opposite edge.
- Frame length:
  - Total bits N = (len+1)×8 when MODE_16B=0, i.e. 8..128.
  - Total bits N = (min(len,7)+1)×16 when MODE_16B=1, i.e. len>7 clamps to 128 bits.
- FSM IDLE:
  - On `slv_ctrl[7]` 0→1: latch `slv_wfifo` into the TX shift register and latch len.
  - Clear `status[6:0]`, set `status[7]`=1, go to ARMED.
- FSM ARMED:
  - On synced `ss` falling: load the bit counter with 0, go to SHIFT.
  - If CPHA=0, drive `miso`=tx[127] immediately.
  - If CPHA=1, drive the first bit on the first shift edge.
- FSM SHIFT:
  - Each sample edge: rx shift register ← {rx[126:0], mosi}, counter+1.
  - Each shift edge: TX shifts left by 1 and `miso`=new tx[127]. With CPHA=0, skip the shift edge that follows the final sample.
  - When the counter reaches N: `slv_rfifo` ← rx left-aligned (rx << (128−N)); `status[6]`=1; `status[3:0]`=len (clamped value); go to DONE.
- FSM DONE:
  - `miso`=0. Further `scl` edges while `ss` is low are ignored and set `status[5]` (overrun).
  - Synced `ss` rising: `status[7]`=0, go to IDLE.
- Short frame: synced `ss` rising while in SHIFT.
  - `slv_rfifo` ← the received partial bits, left-aligned, lower bits 0.
  - `status[4]`=1, `status[6]`=0.
  - `status[3:0]` = complete units − 1, or 0 if none.
  - `status[7]`=0, go to IDLE.
- `ss` low while IDLE: no arm, so `miso` stays 0, `mosi` is ignored and no status changes.
- `ss` rising in ARMED: stays ARMED.
- Arm edge outside IDLE: ignored. `slv_wfifo`/`slv_ctrl` changes after the arm latch have no effect on the current frame.
- Arm edge in the same cycle as the `ss` fall: the arm is taken, and the `ss` fall is acted on next cycle if `ss` is still low.
- `status[7]` stays high until `ss` deasserts, matching the master handshake: the host waits for busy to fall.
- Reset mid-frame: immediate return to reset values; a partial frame is discarded.

Test Plan:
- Mode 0, 8-bit, len=7, arm with `slv_wfifo`={4{32'hCAFE_EFAB}}; master sends {16{8'h5a}}, len=7 → master `rfifo[127:64]`=64'hCAFEEFABCAFEEFAB; `slv_rfifo`={8{8'h5a}},64'h0; status=8'h47 after `ss` high.
- CPOL=1, CPHA=1, 8-bit, len=5, TX {4{32'hBABE_FACE}} → master receives 48'hBABEFACEBABE; `slv_rfifo[127:80]`=48'h5a5a5a5a5a5a; `status[3:0]`=5.
- MODE_16B=1, len=9 (clamped to 7), 128-bit frame of all-1 from master → `slv_rfifo`=all-ones; `status[3:0]`=7; no overrun.
- Master drives `ss` high after 12 bits (8-bit mode, len=3) → `status[4]`=1, `status[6]`=0, `status[3:0]`=0; `slv_rfifo[127:116]` holds the 12 bits, the rest 0; busy=0.
- Master clocks 16 bits with len=0 → first 8 bits captured; `status[5]`=1, `status[6]`=1; `miso`=0 during bits 9–16.
- `rstn` pulsed during bit 20 of a 64-bit frame → all outputs 0 within 1 clk; a new arm plus frame then completes correctly.
